// File: rtl/ext_pkg.sv
// Shared op codes for the pipelined immediate/load-data extender.
package ext_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] EXT_SIGN  = 3'b000;
  localparam logic [OP_W-1:0] EXT_ZERO  = 3'b001;
  localparam logic [OP_W-1:0] EXT_UPPER = 3'b010;
  localparam logic [OP_W-1:0] EXT_NONE  = 3'b011;
  localparam logic [OP_W-1:0] EXT_LB    = 3'b100;
  localparam logic [OP_W-1:0] EXT_LBU   = 3'b101;
  localparam logic [OP_W-1:0] EXT_LH    = 3'b110;
  localparam logic [OP_W-1:0] EXT_LHU   = 3'b111;

endpackage

// File: rtl/ext_lane_sel.sv
// Picks the byte or halfword lane a load refers to (little-endian) and
// flags halfword loads at an odd byte offset.
module ext_lane_sel
  import ext_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]           word,
  input  logic [$clog2(DATA_W/8)-1:0] byte_off,
  input  logic [OP_W-1:0]             op,
  output logic [15:0]                 lane,
  output logic                        misalign
);

  localparam int OFF_W = $clog2(DATA_W/8);

  logic [OFF_W-1:0] hw_base;
  logic [7:0]       byte_val;
  logic [15:0]      half_val;

  always_comb begin
    lane     = '0;
    misalign = 1'b0;
    hw_base  = byte_off & ~(OFF_W'(1));
    byte_val = word[{byte_off, 3'b000} +: 8];
    half_val = word[{hw_base, 3'b000} +: 16];
    case (op)
      EXT_LB, EXT_LBU: lane = {8'h00, byte_val};
      EXT_LH, EXT_LHU: begin
        // A misaligned halfword yields zero data so the extended result is 0.
        if (byte_off[0]) misalign = 1'b1;
        else             lane     = half_val;
      end
      default: lane = '0;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Two-stage valid/ready extender: s1 selects the load lane, s2 extends
// to DATA_W. Flush drops both stages; reset clears everything.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OP_W-1:0]             op,
  input  logic [IMM_W-1:0]            imm,
  input  logic [DATA_W-1:0]           word,
  input  logic [$clog2(DATA_W/8)-1:0] byte_off,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out,
  output logic                        err
);

  logic              s1_valid;
  logic [OP_W-1:0]   s1_op;
  logic [IMM_W-1:0]  s1_imm;
  logic [15:0]       s1_lane;
  logic              s1_err;
  logic              s2_valid;

  logic [15:0]       sel_lane;
  logic              sel_misalign;
  logic              s2_load;
  logic              s1_adv;
  logic [DATA_W-1:0] ext_val;

  ext_lane_sel #(.DATA_W(DATA_W)) u_lane_sel (
    .word     (word),
    .byte_off (byte_off),
    .op       (op),
    .lane     (sel_lane),
    .misalign (sel_misalign)
  );

  // in_ready depends only on stage occupancy and out_ready, never on in_valid.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_load;
  assign in_ready  = !s1_valid || s1_adv;
  assign out_valid = s2_valid;

  always_comb begin
    ext_val = '0;
    case (s1_op)
      EXT_SIGN:  ext_val = DATA_W'($signed(s1_imm));
      EXT_ZERO:  ext_val = DATA_W'(s1_imm);
      EXT_UPPER: ext_val = DATA_W'(s1_imm) << (DATA_W - IMM_W);
      EXT_NONE:  ext_val = '0;
      EXT_LB:    ext_val = DATA_W'($signed(s1_lane[7:0]));
      EXT_LBU:   ext_val = DATA_W'(s1_lane[7:0]);
      EXT_LH:    ext_val = DATA_W'($signed(s1_lane));
      EXT_LHU:   ext_val = DATA_W'(s1_lane);
      default:   ext_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_imm   <= '0;
      s1_lane  <= '0;
      s1_err   <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op   <= op;
        s1_imm  <= imm;
        s1_lane <= sel_lane;
        s1_err  <= sel_misalign;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      out      <= '0;
      err      <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out <= ext_val;
        err <= s1_err;
      end
    end
  end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
Parametrised, pipelined successor to the single-cycle immediate extender. It performs immediate extension (sign, zero, upper-place, zero-out) and load-data extension (lb/lbu/lh/lhu byte-lane select plus extend) in one unit. Two registered stages use a valid/ready handshake, and a flush input is provided. It sits between the decode/memory stage and its consumer; the CPU pipeline stalls through ready.

Parameters:
DATA_W, 32, output and load-word width; multiple of 16, at least 2*IMM_W
IMM_W, 16, immediate width
OFF_W, $clog2(DATA_W/8), byte-offset width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
flush  in  1  drop all in-flight operations
in_valid  in  1  request present
in_ready  out  1  unit accepts request this cycle
op  in  3  operation code (see Behaviour)
imm  in  IMM_W  immediate operand
word  in  DATA_W  loaded memory word (load ops)
byte_off  in  OFF_W  byte address offset within word (load ops)
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out  out  DATA_W  extended result
err  out  1  misaligned halfword load; qualified by out_valid

Behaviour:
- Op codes:
  - 000 sign-extend imm.
  - 001 zero-extend imm.
  - 010 imm placed in top IMM_W bits, low bits 0.
  - 011 result 0.
  - 100 lb: sign-extend byte at lane byte_off.
  - 101 lbu: zero-extend byte at lane byte_off.
  - 110 lh: sign-extend halfword at lanes {byte_off[OFF_W-1:1],0}.
  - 111 lhu: zero-extend halfword at the same lanes.
- Lane order is little-endian: lane k = word[8k+7:8k].
- Halfword ops with byte_off[0]=1: err=1, out=0.
- err is 0 for every other op.
- Stage 1 (s1) registers op, the selected lane data (16 bits) and the err flag on a handshake.
- Stage 2 (s2) registers the extended out and err. Latency is 2 cycles from accept to out_valid when unstalled.
- Throughput is 1 per cycle.
- Handshake rules:
  - Input transfer happens when in_valid and in_ready.
  - Output transfer happens when out_valid and out_ready.
  - s2 may load when !s2_valid or out_ready.
  - s1 advances into s2 when s1_valid and s2 may load.
  - in_ready = !s1_valid or s1 advances (combinational from out_ready; no comb path from in_valid).
  - With both stages full and out_ready=0: in_ready=0, and all registers hold.
  - out and err stay stable while out_valid and !out_ready.
- Flush: on the next edge, s1_valid=0 and s2_valid=0. A request offered in the flush cycle is discarded; in_ready may be 1, but nothing is captured. A result transferring in the flush cycle counts as delivered.
- Reset (asynchronous, any time, including mid-stall):
  - s1_valid=0, s2_valid=0, out=0, err=0.
  - All data registers go to 0.
  - in_ready=1 immediately after reset deasserts.
- Width rules: sign extension replicates bit IMM_W-1, bit 7 or bit 15 respectively. No truncation occurs.
- Data registers do not need to be cleared when the stage goes invalid; out is only meaningful with out_valid. Exception: out and err must read 0 after reset.

Decomposition:
- Shared package ext_pkg: op-code localparams (EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_NONE, EXT_LB, EXT_LBU, EXT_LH, EXT_LHU) and the op width constant 3.
- One combinational sub-module, ext_lane_sel (word, byte_off, op → 16-bit lane data, misalign flag), instantiated in s1. The extend mux lives in ext_pipe s2.

Test Plan:
- Immediate ops, out_ready=1, imm=16'h8001:
  - op 000 → out 32'hFFFF8001.
  - op 001 → 32'h00008001.
  - op 010 → 32'h80010000.
  - op 011 → 0.
  - Each appears exactly 2 cycles after accept.
- Loads with word=32'h80FF7F01:
  - lb, off 1 → 32'h0000007F.
  - lb, off 2 → 32'hFFFFFFFF.
  - lbu, off 3 → 32'h00000080.
  - lh, off 2 → 32'hFFFF80FF.
  - lhu, off 0 → 32'h00007F01.
  - err=0 for all.
- Misaligned: lh with off 1 and lhu with off 3 → out 0, err=1. The following aligned op has err=0.
- Backpressure:
  - Stream 4 back-to-back requests and hold out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepts.
  - The first result stays stable.
  - On release, all 4 results arrive in order with none lost or duplicated.
- Flush with both stages full and a new request offered in the same cycle → next cycle out_valid=0, and the offered request never appears.
- Reset asserted asynchronously mid-stall (between clock edges) → out_valid, out and err go to 0 immediately, and in_ready=1 after deassertion.
